// File: rtl/subservient_dbg_loader.sv
// Wishbone initiator that streams firmware bytes into the subservient debug port,
// packing them little-endian into 32-bit single-beat writes and holding the core in reset meanwhile.
module subservient_dbg_loader #(
  parameter int LEN_W  = 16,
  parameter int TO_CYC = 255
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_start,
  input  logic [31:0]      i_base_adr,
  input  logic [LEN_W-1:0] i_len_words,
  input  logic [7:0]       i_byte,
  input  logic             i_byte_vld,
  output logic             o_byte_rdy,
  output logic [31:0]      o_wb_adr,
  output logic [31:0]      o_wb_dat,
  output logic [3:0]       o_wb_sel,
  output logic             o_wb_we,
  output logic             o_wb_stb,
  input  logic             i_wb_ack,
  output logic             o_debug_mode,
  output logic             o_core_rst,
  output logic             o_busy,
  output logic             o_done,
  output logic             o_err
);

  typedef enum logic [2:0] {IDLE, COLLECT, WRITE, DONE, ERR} state_t;

  state_t           state, state_d;
  logic [31:0]      base, adr, dat;
  logic [LEN_W-1:0] len, idx, idx_inc;
  logic [1:0]       bcnt;
  logic [15:0]      to_cnt;
  logic             err, core_rst, debug_mode;
  logic             go, take, acked, timeout;

  assign go      = i_start && (state == IDLE || state == ERR);
  assign take    = (state == COLLECT) && i_byte_vld;
  assign acked   = (state == WRITE) && i_wb_ack;
  assign timeout = (state == WRITE) && !i_wb_ack && (to_cnt == 16'(TO_CYC - 1));
  assign idx_inc = idx + 1'b1;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) state <= IDLE;
    else       state <= state_d;
  end

  always_comb begin
    state_d = state;
    case (state)
      IDLE, ERR: if (i_start) state_d = (i_len_words == '0) ? DONE : COLLECT;
      COLLECT:   if (take && bcnt == 2'd3) state_d = WRITE;
      WRITE: begin
        if (i_wb_ack)     state_d = (idx_inc == len) ? DONE : COLLECT;
        else if (timeout) state_d = ERR;
      end
      DONE:      state_d = IDLE;
      default:   state_d = IDLE;
    endcase
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      base       <= '0;
      len        <= '0;
      idx        <= '0;
      bcnt       <= '0;
      dat        <= '0;
      adr        <= '0;
      to_cnt     <= '0;
      err        <= 1'b0;
      core_rst   <= 1'b1;
      debug_mode <= 1'b0;
    end else begin
      if (go) begin
        base <= i_base_adr;
        len  <= i_len_words;
        idx  <= '0;
        bcnt <= '0;
        err  <= 1'b0;
      end
      if (take) begin
        dat[{bcnt, 3'b000} +: 8] <= i_byte;
        bcnt                     <= bcnt + 2'd1;
      end
      // Address is frozen on entry to WRITE so it stays stable for the whole strobe.
      if (state == COLLECT && state_d == WRITE) begin
        adr    <= base + (32'(idx) << 2);
        to_cnt <= '0;
      end
      if (state == WRITE && !i_wb_ack) to_cnt <= to_cnt + 16'd1;
      if (acked)   idx <= idx_inc;
      if (timeout) err <= 1'b1;
      // A zero-length start goes straight to DONE, so the release must win over go.
      if (state_d == DONE)  core_rst <= 1'b0;
      else if (go)          core_rst <= 1'b1;
      if (state_d == DONE || state_d == ERR) debug_mode <= 1'b0;
      else if (go)                           debug_mode <= 1'b1;
    end
  end

  assign o_byte_rdy   = (state == COLLECT);
  assign o_wb_stb     = (state == WRITE);
  assign o_wb_we      = (state == WRITE);
  assign o_wb_sel     = (state == WRITE) ? 4'hF : 4'h0;
  assign o_wb_adr     = adr;
  assign o_wb_dat     = dat;
  assign o_busy       = (state == COLLECT) || (state == WRITE);
  assign o_done       = (state == DONE);
  assign o_err        = err;
  assign o_core_rst   = core_rst;
  assign o_debug_mode = debug_mode;

endmodule

// File: tb/tb_subservient_dbg_loader.sv
// Directed bench for subservient_dbg_loader: a Wishbone responder with programmable ack delay,
// a byte feeder, and a write log checked against hand-computed words and addresses.
module tb_subservient_dbg_loader;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic [31:0] base_adr = '0;
  logic [15:0] len_words = '0;
  logic [7:0]  byte_d = '0;
  logic        byte_vld = 1'b0;
  logic        sel_to = 1'b0;
  logic        ack = 1'b0;
  logic        stray = 1'b0;
  logic        never_ack = 1'b0;
  int          ack_dly = 1;

  always #5 clk = ~clk;

  logic        start_a, start_b, ack_a, ack_b;
  logic        rdy_a, stb_a, we_a, dbg_a, crst_a, busy_a, done_a, err_a;
  logic        rdy_b, stb_b, we_b, dbg_b, crst_b, busy_b, done_b, err_b;
  logic [31:0] adr_a, dat_a, adr_b, dat_b;
  logic [3:0]  sel_a, sel_b;

  assign start_a = start & ~sel_to;
  assign start_b = start & sel_to;
  assign ack_a   = ack & ~sel_to;
  assign ack_b   = ack & sel_to;

  subservient_dbg_loader #(.LEN_W(16), .TO_CYC(255)) dut (
    .i_clk(clk), .i_rst(rst), .i_start(start_a), .i_base_adr(base_adr), .i_len_words(len_words),
    .i_byte(byte_d), .i_byte_vld(byte_vld), .o_byte_rdy(rdy_a),
    .o_wb_adr(adr_a), .o_wb_dat(dat_a), .o_wb_sel(sel_a), .o_wb_we(we_a), .o_wb_stb(stb_a),
    .i_wb_ack(ack_a), .o_debug_mode(dbg_a), .o_core_rst(crst_a), .o_busy(busy_a),
    .o_done(done_a), .o_err(err_a)
  );

  subservient_dbg_loader #(.LEN_W(16), .TO_CYC(8)) dut_to (
    .i_clk(clk), .i_rst(rst), .i_start(start_b), .i_base_adr(base_adr), .i_len_words(len_words),
    .i_byte(byte_d), .i_byte_vld(byte_vld), .o_byte_rdy(rdy_b),
    .o_wb_adr(adr_b), .o_wb_dat(dat_b), .o_wb_sel(sel_b), .o_wb_we(we_b), .o_wb_stb(stb_b),
    .i_wb_ack(ack_b), .o_debug_mode(dbg_b), .o_core_rst(crst_b), .o_busy(busy_b),
    .o_done(done_b), .o_err(err_b)
  );

  logic        m_rdy, m_stb, m_we, m_dbg, m_crst, m_busy, m_done, m_err;
  logic [31:0] m_adr, m_dat;
  logic [3:0]  m_sel;

  assign m_rdy  = sel_to ? rdy_b  : rdy_a;
  assign m_stb  = sel_to ? stb_b  : stb_a;
  assign m_we   = sel_to ? we_b   : we_a;
  assign m_dbg  = sel_to ? dbg_b  : dbg_a;
  assign m_crst = sel_to ? crst_b : crst_a;
  assign m_busy = sel_to ? busy_b : busy_a;
  assign m_done = sel_to ? done_b : done_a;
  assign m_err  = sel_to ? err_b  : err_a;
  assign m_adr  = sel_to ? adr_b  : adr_a;
  assign m_dat  = sel_to ? dat_b  : dat_a;
  assign m_sel  = sel_to ? sel_b  : sel_a;

  int errors = 0;
  int checks = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got=%08h exp=%08h", tag, got, exp);
    end
  endtask

  // Responder and monitor, sampled on the falling edge.
  int          stb_run = 0, last_run = 0, stb_rises = 0, unstable = 0, rdy_in_write = 0;
  int          done_cnt = 0, wr_cnt = 0;
  logic [31:0] f_adr = '0, f_dat = '0;
  logic [3:0]  f_sel = '0;
  logic [31:0] wr_adr [0:31];
  logic [31:0] wr_dat [0:31];
  logic [4:0]  wr_wesel [0:31];

  always @(negedge clk) begin
    if (m_stb) begin
      stb_run++;
      if (stb_run == 1) begin
        f_adr = m_adr; f_dat = m_dat; f_sel = m_sel;
        stb_rises++;
      end else if (m_adr !== f_adr || m_dat !== f_dat || m_sel !== f_sel) begin
        unstable++;
      end
      if (m_rdy) rdy_in_write++;
      if (!never_ack && stb_run == ack_dly) begin
        ack = 1'b1;
        if (wr_cnt < 32) begin
          wr_adr[wr_cnt]   = m_adr;
          wr_dat[wr_cnt]   = m_dat;
          wr_wesel[wr_cnt] = {m_we, m_sel};
        end
        wr_cnt++;
      end else begin
        ack = stray;
      end
    end else begin
      if (stb_run != 0) last_run = stb_run;
      stb_run = 0;
      ack = stray;
    end
    if (m_done) done_cnt++;
  end

  logic [7:0] stim [0:7];
  int         feed_tmo = 0;
  int         b_wr, b_done, b_rises, b_unst, b_rdyw;

  task automatic load_stim(input logic [63:0] v);
    for (int i = 0; i < 8; i++) stim[i] = v[8*i +: 8];
  endtask

  task automatic snap();
    b_wr = wr_cnt; b_done = done_cnt; b_rises = stb_rises; b_unst = unstable; b_rdyw = rdy_in_write;
  endtask

  task automatic feed(input int n, input int gap);
    int tmo;
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      byte_d   = stim[i];
      byte_vld = 1'b1;
      tmo = 0;
      while (!m_rdy && tmo < 100) begin
        @(negedge clk);
        tmo++;
      end
      if (tmo >= 100) feed_tmo++;
      @(posedge clk);
      #1 byte_vld = 1'b0;
      repeat (gap) @(negedge clk);
    end
  endtask

  task automatic do_start(input logic [31:0] b, input logic [15:0] l);
    @(negedge clk);
    base_adr  = b;
    len_words = l;
    start     = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_done(input string tag);
    logic seen = 1'b0;
    for (int i = 0; i < 300 && !seen; i++) begin
      @(negedge clk);
      seen = m_done;
    end
    chk(tag, 32'(seen), 32'd1);
  endtask

  task automatic wait_err(input string tag);
    logic seen = 1'b0;
    for (int i = 0; i < 300 && !seen; i++) begin
      @(negedge clk);
      seen = m_err;
    end
    chk(tag, 32'(seen), 32'd1);
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_stb"},  32'(m_stb),  32'd0);
    chk({tag, "_we"},   32'(m_we),   32'd0);
    chk({tag, "_sel"},  32'(m_sel),  32'd0);
    chk({tag, "_adr"},  m_adr,       32'd0);
    chk({tag, "_dat"},  m_dat,       32'd0);
    chk({tag, "_rdy"},  32'(m_rdy),  32'd0);
    chk({tag, "_dbg"},  32'(m_dbg),  32'd0);
    chk({tag, "_crst"}, 32'(m_crst), 32'd1);
    chk({tag, "_busy"}, 32'(m_busy), 32'd0);
    chk({tag, "_done"}, 32'(m_done), 32'd0);
    chk({tag, "_err"},  32'(m_err),  32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (3) @(negedge clk);
    chk_reset_vals("rst");
    rst = 1'b0;

    // Basic two-word load, back-to-back bytes, ack in first strobe cycle.
    snap();
    load_stim(64'h8877665544332211);
    ack_dly = 1;
    do_start(32'h0000_0000, 16'd2);
    chk("b_busy", 32'(m_busy), 32'd1);
    chk("b_dbg",  32'(m_dbg),  32'd1);
    chk("b_crst", 32'(m_crst), 32'd1);
    feed(8, 0);
    wait_done("b_done_seen");
    repeat (2) @(negedge clk);
    chk("b_nwr",   32'(wr_cnt - b_wr),     32'd2);
    chk("b_adr0",  wr_adr[b_wr],           32'h0000_0000);
    chk("b_dat0",  wr_dat[b_wr],           32'h4433_2211);
    chk("b_wes0",  32'(wr_wesel[b_wr]),    32'h1F);
    chk("b_adr1",  wr_adr[b_wr+1],         32'h0000_0004);
    chk("b_dat1",  wr_dat[b_wr+1],         32'h8877_6655);
    chk("b_wes1",  32'(wr_wesel[b_wr+1]),  32'h1F);
    chk("b_ndone", 32'(done_cnt - b_done), 32'd1);
    chk("b_crst0", 32'(m_crst),            32'd0);
    chk("b_dbg0",  32'(m_dbg),             32'd0);
    chk("b_idle",  32'(m_busy),            32'd0);

    // Zero-length load: done one cycle after start, no strobe.
    snap();
    do_start(32'h0000_0100, 16'd0);
    chk("z_done",  32'(m_done), 32'd1);
    chk("z_crst",  32'(m_crst), 32'd0);
    @(negedge clk);
    chk("z_done1", 32'(m_done), 32'd0);
    chk("z_nstb",  32'(stb_rises - b_rises), 32'd0);

    // Stalled source and slow ack.
    snap();
    load_stim(64'hF0DEBC9A78563412);
    ack_dly = 10;
    do_start(32'h0000_1000, 16'd2);
    feed(8, 3);
    wait_done("s_done_seen");
    repeat (2) @(negedge clk);
    chk("s_rdyw",  32'(rdy_in_write - b_rdyw), 32'd0);
    chk("s_stab",  32'(unstable - b_unst),     32'd0);
    chk("s_rises", 32'(stb_rises - b_rises),   32'd2);
    chk("s_adr0",  wr_adr[b_wr],   32'h0000_1000);
    chk("s_dat0",  wr_dat[b_wr],   32'h7856_3412);
    chk("s_adr1",  wr_adr[b_wr+1], 32'h0000_1004);
    chk("s_dat1",  wr_dat[b_wr+1], 32'hF0DE_BC9A);
    chk("s_runlen", 32'(last_run), 32'd10);

    // Timeout on the TO_CYC=8 instance, then recovery.
    sel_to    = 1'b1;
    never_ack = 1'b1;
    load_stim(64'h00000000D4C3B2A1);
    do_start(32'h0000_2000, 16'd1);
    feed(4, 0);
    wait_err("t_err_seen");
    @(negedge clk);
    chk("t_run",  32'(last_run), 32'd8);
    chk("t_stb",  32'(m_stb),    32'd0);
    chk("t_busy", 32'(m_busy),   32'd0);
    chk("t_crst", 32'(m_crst),   32'd1);
    chk("t_dbg",  32'(m_dbg),    32'd0);
    never_ack = 1'b0;
    ack_dly   = 1;
    snap();
    do_start(32'h0000_2000, 16'd1);
    chk("t_errclr", 32'(m_err), 32'd0);
    feed(4, 0);
    wait_done("t_done_seen");
    @(negedge clk);
    chk("t_nwr",   32'(wr_cnt - b_wr), 32'd1);
    chk("t_adr",   wr_adr[b_wr],      32'h0000_2000);
    chk("t_dat",   wr_dat[b_wr],      32'hD4C3_B2A1);
    chk("t_crst0", 32'(m_crst),       32'd0);
    sel_to = 1'b0;

    // Address wrap and stray ack while strobe is low.
    snap();
    load_stim(64'h0807060504030201);
    do_start(32'hFFFF_FFFC, 16'd2);
    feed(4, 0);
    repeat (3) @(negedge clk);
    stray = 1'b1;
    @(negedge clk);
    @(negedge clk);
    stray = 1'b0;
    chk("w_busy", 32'(m_busy), 32'd1);
    chk("w_rdy",  32'(m_rdy),  32'd1);
    for (int i = 0; i < 4; i++) stim[i] = stim[i+4];
    feed(4, 0);
    wait_done("w_done_seen");
    repeat (2) @(negedge clk);
    chk("w_nwr",   32'(wr_cnt - b_wr),     32'd2);
    chk("w_adr0",  wr_adr[b_wr],           32'hFFFF_FFFC);
    chk("w_dat0",  wr_dat[b_wr],           32'h0403_0201);
    chk("w_adr1",  wr_adr[b_wr+1],         32'h0000_0000);
    chk("w_dat1",  wr_dat[b_wr+1],         32'h0807_0605);
    chk("w_ndone", 32'(done_cnt - b_done), 32'd1);

    // Asynchronous reset during an unacknowledged strobe, then a fresh load.
    never_ack = 1'b1;
    load_stim(64'hCAFEBABEDEADBEEF);
    do_start(32'h0000_3000, 16'd2);
    feed(4, 0);
    @(negedge clk);
    chk("r_stb_pre", 32'(m_stb), 32'd1);
    #2 rst = 1'b1;
    #1 chk_reset_vals("r");
    @(negedge clk);
    rst       = 1'b0;
    never_ack = 1'b0;
    ack_dly   = 1;
    snap();
    do_start(32'h0000_3000, 16'd2);
    feed(8, 0);
    wait_done("r_done_seen");
    repeat (2) @(negedge clk);
    chk("r_nwr",  32'(wr_cnt - b_wr), 32'd2);
    chk("r_adr0", wr_adr[b_wr],       32'h0000_3000);
    chk("r_dat0", wr_dat[b_wr],       32'hDEAD_BEEF);
    chk("r_adr1", wr_adr[b_wr+1],     32'h0000_3004);
    chk("r_dat1", wr_dat[b_wr+1],     32'hCAFE_BABE);
    chk("r_crst", 32'(m_crst),        32'd0);

    chk("feed_tmo", 32'(feed_tmo), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
